// File: rtl/vid_pkg.sv
// Shared constants, register map and FSM state type for the video fill engine.
package vid_pkg;

  localparam int VID_WORDS_PER_ROW = 32;
  localparam int VID_ROWS          = 768;

  localparam logic [4:0] VID_LAST_COL = 5'(VID_WORDS_PER_ROW - 1);
  localparam logic [9:0] VID_LAST_ROW = 10'(VID_ROWS - 1);

  localparam logic [1:0] REG_GEOM = 2'd0;
  localparam logic [1:0] REG_HGT  = 2'd1;
  localparam logic [1:0] REG_PAT  = 2'd2;
  localparam logic [1:0] REG_CMD  = 2'd3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_e;

endpackage

// File: rtl/vid_fill_agen.sv
// Fill address/data generator: clipped x/y walk in row-major order with row-parity pattern inversion.
// On load the first word is taken straight from the inputs so it can be issued in the start cycle.
module vid_fill_agen
  import vid_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        adv_i,
  input  logic [4:0]  x0_i,
  input  logic [4:0]  wm1_i,
  input  logic [9:0]  y0_i,
  input  logic [9:0]  hm1_i,
  input  logic [31:0] pat_i,
  input  logic        inv_i,
  output logic [14:0] addr_o,
  output logic [31:0] data_o,
  output logic        last_o
);

  logic [4:0]  x0_q, xend_q, x_q, x_d;
  logic [9:0]  y0_q, yend_q, y_q, y_d;
  logic [31:0] pat_q;
  logic        inv_q;

  logic [5:0]  xsum;
  logic [10:0] ysum;
  logic [4:0]  xend_new;
  logic [9:0]  yend_new;

  logic [4:0]  cx0, cxe, cx;
  logic [9:0]  cy0, cye, cy;
  logic [31:0] cpat;
  logic        cinv;

  always_comb begin
    xsum     = {1'b0, x0_i} + {1'b0, wm1_i};
    xend_new = xsum[5] ? VID_LAST_COL : xsum[4:0];
    ysum     = {1'b0, y0_i} + {1'b0, hm1_i};
    yend_new = (ysum > {1'b0, VID_LAST_ROW}) ? VID_LAST_ROW : ysum[9:0];
  end

  always_comb begin
    if (load_i) begin
      cx0  = x0_i;
      cxe  = xend_new;
      cy0  = y0_i;
      cye  = yend_new;
      cpat = pat_i;
      cinv = inv_i;
      cx   = x0_i;
      cy   = y0_i;
    end else begin
      cx0  = x0_q;
      cxe  = xend_q;
      cy0  = y0_q;
      cye  = yend_q;
      cpat = pat_q;
      cinv = inv_q;
      cx   = x_q;
      cy   = y_q;
    end
  end

  always_comb begin
    x_d = cx;
    y_d = cy;
    if (adv_i) begin
      if (cx == cxe) begin
        x_d = cx0;
        y_d = cy + 10'd1;
      end else begin
        x_d = cx + 5'd1;
      end
    end
  end

  assign addr_o = {cy, cx};
  assign data_o = (cinv && (cy[0] ^ cy0[0])) ? ~cpat : cpat;
  assign last_o = (cx == cxe) && (cy == cye);

  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q   <= '0;
      xend_q <= '0;
      y0_q   <= '0;
      yend_q <= '0;
      pat_q  <= '0;
      inv_q  <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      if (load_i) begin
        x0_q   <= cx0;
        xend_q <= cxe;
        y0_q   <= cy0;
        yend_q <= cye;
        pat_q  <= cpat;
        inv_q  <= cinv;
      end
      if (load_i || adv_i) begin
        x_q <= x_d;
        y_q <= y_d;
      end
    end
  end

endmodule

// File: rtl/vid_fill.sv
// Rectangle fill engine sharing the video write port with the CPU; CPU writes always win.
//   state  | meaning
//   S_IDLE | no fill pending; CPU writes pass through
//   S_FILL | fill words remain to be issued
module vid_fill
  import vid_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ctl_stb,
  input  logic        ctl_we,
  input  logic [1:0]  ctl_addr,
  input  logic [31:0] ctl_data_in,
  output logic [31:0] ctl_data_out,
  input  logic        cpu_stb,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [31:0] cpu_data_in,
  output logic        vid_stb,
  output logic        vid_we,
  output logic [14:0] vid_addr,
  output logic [31:0] vid_data,
  output logic        busy,
  output logic        done
);

  state_e      state_q, state_d;
  logic [4:0]  x0_q, wm1_q;
  logic [9:0]  y0_q, hm1_q;
  logic [31:0] pat_q;
  logic        busy_q, busy_d, done_q, done_d, fin_q, fin_d;
  logic        vstb_q, vstb_d;
  logic [14:0] vaddr_q, vaddr_d;
  logic [31:0] vdata_q, vdata_d;

  logic        cpu_wr, ctl_wr, start_req, start_ok, start_oob, fill_req, adv;
  logic [14:0] fill_addr;
  logic [31:0] fill_data;
  logic        fill_last;

  assign cpu_wr    = cpu_stb & cpu_we;
  assign ctl_wr    = ctl_stb & ctl_we;
  assign start_req = ctl_wr && (ctl_addr == REG_CMD) && ctl_data_in[0] && (state_q == S_IDLE);
  assign start_ok  = start_req && (y0_q <= VID_LAST_ROW);
  assign start_oob = start_req && (y0_q > VID_LAST_ROW);
  assign fill_req  = (state_q == S_FILL) || start_ok;
  assign adv       = fill_req && !cpu_wr;

  vid_fill_agen u_agen (
    .clk    (clk),
    .rst    (rst),
    .load_i (start_ok),
    .adv_i  (adv),
    .x0_i   (x0_q),
    .wm1_i  (wm1_q),
    .y0_i   (y0_q),
    .hm1_i  (hm1_q),
    .pat_i  (pat_q),
    .inv_i  (ctl_data_in[1]),
    .addr_o (fill_addr),
    .data_o (fill_data),
    .last_o (fill_last)
  );

  always_comb begin
    ctl_data_out = '0;
    case (ctl_addr)
      REG_GEOM: ctl_data_out = {6'd0, y0_q, 3'd0, wm1_q, 3'd0, x0_q};
      REG_HGT:  ctl_data_out = {22'd0, hm1_q};
      REG_PAT:  ctl_data_out = pat_q;
      default:  ctl_data_out = {31'd0, busy_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    fin_d   = adv && fill_last;
    if (start_ok) state_d = S_FILL;
    if (fin_d)    state_d = S_IDLE;
    // busy covers the cycle in which the final word sits on vid_*
    busy_d  = (state_d == S_FILL) || fin_d;
    done_d  = fin_q || start_oob;
    vstb_d  = 1'b0;
    vaddr_d = vaddr_q;
    vdata_d = vdata_q;
    if (cpu_wr) begin
      vstb_d  = 1'b1;
      vaddr_d = cpu_addr;
      vdata_d = cpu_data_in;
    end else if (adv) begin
      vstb_d  = 1'b1;
      vaddr_d = fill_addr;
      vdata_d = fill_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      wm1_q   <= '0;
      y0_q    <= '0;
      hm1_q   <= '0;
      pat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fin_q   <= 1'b0;
      vstb_q  <= 1'b0;
      vaddr_q <= '0;
      vdata_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fin_q   <= fin_d;
      vstb_q  <= vstb_d;
      vaddr_q <= vaddr_d;
      vdata_q <= vdata_d;
      if (ctl_wr) begin
        case (ctl_addr)
          REG_GEOM: begin
            x0_q  <= ctl_data_in[4:0];
            wm1_q <= ctl_data_in[12:8];
            y0_q  <= ctl_data_in[25:16];
          end
          REG_HGT: hm1_q <= ctl_data_in[9:0];
          REG_PAT: pat_q <= ctl_data_in;
          default: ;
        endcase
      end
    end
  end

  assign vid_stb  = vstb_q;
  assign vid_we   = vstb_q;
  assign vid_addr = vaddr_q;
  assign vid_data = vdata_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_vid_fill.sv
// Directed bench for vid_fill: fills, clipping, checkerboard, CPU arbitration, reset abort, out-of-range start.
module tb_vid_fill;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ctl_stb = 1'b0, ctl_we = 1'b0;
  logic [1:0]  ctl_addr = 2'd0;
  logic [31:0] ctl_data_in = '0;
  logic [31:0] ctl_data_out;
  logic        cpu_stb = 1'b0, cpu_we = 1'b0;
  logic [14:0] cpu_addr = '0;
  logic [31:0] cpu_data_in = '0;
  logic        vid_stb, vid_we, busy, done;
  logic [14:0] vid_addr;
  logic [31:0] vid_data;

  int tests = 0;
  int fails = 0;

  vid_fill dut (
    .clk(clk), .rst(rst),
    .ctl_stb(ctl_stb), .ctl_we(ctl_we), .ctl_addr(ctl_addr),
    .ctl_data_in(ctl_data_in), .ctl_data_out(ctl_data_out),
    .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .vid_stb(vid_stb), .vid_we(vid_we), .vid_addr(vid_addr), .vid_data(vid_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // write/done log sampled mid-cycle
  int          cyc = 0;
  int          wr_n = 0;
  int          dn_n = 0;
  int          dn_t = 0;
  logic [14:0] la [256];
  logic [31:0] ld [256];
  int          lt [256];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (vid_stb) begin
      if (wr_n < 256) begin
        la[wr_n] = vid_addr;
        ld[wr_n] = vid_data;
        lt[wr_n] = cyc;
      end
      wr_n = wr_n + 1;
    end
    if (done) begin
      dn_n = dn_n + 1;
      dn_t = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic ctl_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    ctl_stb = 1'b1; ctl_we = 1'b1; ctl_addr = a; ctl_data_in = d;
    @(negedge clk);
    ctl_stb = 1'b0; ctl_we = 1'b0; ctl_data_in = '0;
  endtask

  task automatic ctl_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    ctl_addr = a;
    #1;
    chk(tag, ctl_data_out, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int w0, d0;
  logic [14:0] ea [8];

  initial begin
    // reset
    idle(3);
    rst = 1'b0;
    chk("rst_vid_stb", 32'(vid_stb), 32'd0);
    chk("rst_vid_addr", 32'(vid_addr), 32'd0);
    chk("rst_vid_data", vid_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    ctl_read("rst_geom", 2'd0, 32'd0);
    ctl_read("rst_pat", 2'd2, 32'd0);
    ctl_read("rst_stat", 2'd3, 32'd0);

    // basic fill
    ctl_write(2'd0, 32'h000A_0302);
    ctl_write(2'd1, 32'h0000_0001);
    ctl_write(2'd2, 32'hA5A5_A5A5);
    ctl_read("geom_rb", 2'd0, 32'h000A_0302);
    ctl_read("hgt_rb", 2'd1, 32'h0000_0001);
    ctl_read("pat_rb", 2'd2, 32'hA5A5_A5A5);
    idle(1);
    w0 = wr_n; d0 = dn_n;
    ctl_write(2'd3, 32'd1);
    chk("basic_busy_n1", 32'(busy), 32'd1);
    chk("basic_first_stb", 32'(vid_stb), 32'd1);
    chk("basic_first_addr", 32'(vid_addr), 32'h142);
    ctl_addr = 2'd3; #1;
    chk("basic_stat_busy", ctl_data_out, 32'd1);
    idle(12);
    ea = '{15'h142, 15'h143, 15'h144, 15'h145, 15'h162, 15'h163, 15'h164, 15'h165};
    chk("basic_count", 32'(wr_n - w0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("basic_addr%0d", i), 32'(la[w0+i]), 32'(ea[i]));
      chk($sformatf("basic_data%0d", i), ld[w0+i], 32'hA5A5_A5A5);
    end
    chk("basic_consecutive", 32'(lt[w0+7] - lt[w0]), 32'd7);
    chk("basic_done_cnt", 32'(dn_n - d0), 32'd1);
    chk("basic_done_time", 32'(dn_t - lt[w0+7]), 32'd1);
    chk("basic_busy_end", 32'(busy), 32'd0);

    // start while busy: ignored, working copy unaffected by register writes
    w0 = wr_n; d0 = dn_n;
    ctl_write(2'd3, 32'd1);
    ctl_write(2'd0, 32'h0000_0000);
    ctl_write(2'd3, 32'd1);
    idle(12);
    chk("rebusy_count", 32'(wr_n - w0), 32'd8);
    chk("rebusy_last_addr", 32'(la[w0+7]), 32'h165);
    chk("rebusy_done_cnt", 32'(dn_n - d0), 32'd1);

    // clipping
    ctl_write(2'd0, 32'h02FE_051E);
    ctl_write(2'd1, 32'd4);
    w0 = wr_n; d0 = dn_n;
    ctl_write(2'd3, 32'd1);
    idle(10);
    chk("clip_count", 32'(wr_n - w0), 32'd4);
    chk("clip_a0", 32'(la[w0]),   32'h5FDE);
    chk("clip_a1", 32'(la[w0+1]), 32'h5FDF);
    chk("clip_a2", 32'(la[w0+2]), 32'h5FFE);
    chk("clip_a3", 32'(la[w0+3]), 32'h5FFF);
    chk("clip_done_cnt", 32'(dn_n - d0), 32'd1);

    // checkerboard
    ctl_write(2'd0, 32'h0);
    ctl_write(2'd1, 32'd2);
    ctl_write(2'd2, 32'hFFFF_0000);
    w0 = wr_n;
    ctl_write(2'd3, 32'd3);
    idle(8);
    chk("chk_count", 32'(wr_n - w0), 32'd3);
    chk("chk_d0", ld[w0],   32'hFFFF_0000);
    chk("chk_d1", ld[w0+1], 32'h0000_FFFF);
    chk("chk_d2", ld[w0+2], 32'hFFFF_0000);
    chk("chk_a2", 32'(la[w0+2]), 32'h40);

    // CPU preempts the fill in its second cycle
    ctl_write(2'd0, 32'h0000_0300);
    ctl_write(2'd1, 32'd0);
    ctl_write(2'd2, 32'hCAFE_F00D);
    w0 = wr_n; d0 = dn_n;
    ctl_write(2'd3, 32'd1);
    cpu_stb = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0001; cpu_data_in = 32'h1234_5678;
    @(negedge clk);
    cpu_stb = 1'b0; cpu_we = 1'b0;
    idle(8);
    chk("arb_count", 32'(wr_n - w0), 32'd5);
    chk("arb_a0", 32'(la[w0]), 32'h0);
    chk("arb_d0", ld[w0], 32'hCAFE_F00D);
    chk("arb_a1", 32'(la[w0+1]), 32'h1);
    chk("arb_d1", ld[w0+1], 32'h1234_5678);
    chk("arb_a2", 32'(la[w0+2]), 32'h1);
    chk("arb_d2", ld[w0+2], 32'hCAFE_F00D);
    chk("arb_a3", 32'(la[w0+3]), 32'h2);
    chk("arb_a4", 32'(la[w0+4]), 32'h3);
    chk("arb_consecutive", 32'(lt[w0+4] - lt[w0]), 32'd4);
    chk("arb_done_time", 32'(dn_t - lt[w0+4]), 32'd1);
    chk("arb_done_cnt", 32'(dn_n - d0), 32'd1);

    // idle CPU write, one-cycle latency
    @(negedge clk);
    cpu_stb = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h7FFF; cpu_data_in = 32'hDEAD_BEEF;
    @(negedge clk);
    cpu_stb = 1'b0; cpu_we = 1'b0;
    chk("cpu_idle_stb", 32'(vid_stb), 32'd1);
    chk("cpu_idle_addr", 32'(vid_addr), 32'h7FFF);
    chk("cpu_idle_data", vid_data, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("cpu_idle_stb_off", 32'(vid_stb), 32'd0);

    // out-of-range start
    ctl_write(2'd0, 32'h0320_0000);
    w0 = wr_n; d0 = dn_n;
    ctl_write(2'd3, 32'd1);
    chk("oob_done_n1", 32'(done), 32'd1);
    chk("oob_busy_n1", 32'(busy), 32'd0);
    chk("oob_stb_n1", 32'(vid_stb), 32'd0);
    @(negedge clk);
    chk("oob_done_n2", 32'(done), 32'd0);
    idle(4);
    chk("oob_count", 32'(wr_n - w0), 32'd0);
    chk("oob_done_cnt", 32'(dn_n - d0), 32'd1);

    // reset aborts a full-screen fill; rst beats a simultaneous CPU write
    ctl_write(2'd0, 32'h0000_1F00);
    ctl_write(2'd1, 32'h0000_02FF);
    w0 = wr_n; d0 = dn_n;
    ctl_write(2'd3, 32'd1);
    idle(20);
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    cpu_stb = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0123; cpu_data_in = 32'h5555_AAAA;
    @(negedge clk);
    cpu_stb = 1'b0; cpu_we = 1'b0;
    chk("abort_stb", 32'(vid_stb), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_addr", 32'(vid_addr), 32'd0);
    rst = 1'b0;
    w0 = wr_n;
    idle(10);
    chk("abort_no_writes", 32'(wr_n - w0), 32'd0);
    chk("abort_no_done", 32'(dn_n - d0), 32'd0);
    ctl_read("abort_geom_cleared", 2'd0, 32'd0);
    ctl_read("abort_stat", 2'd3, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vid_fill.md
VID_FILL -- requirements
Module: vid_fill

Interface
REQ-001 clk  in  1  system clock, same clock as the video controller write port.
REQ-002 rst  in  1  reset; one clock, synchronous, active-high.
REQ-003 ctl_stb  in  1  control register access strobe.
REQ-004 ctl_we  in  1  control write enable (1=write, 0=read).
REQ-005 ctl_addr  in  2  register select: 0=GEOM, 1=HGT, 2=PAT, 3=CMD/STAT.
REQ-006 ctl_data_in  in  32  control write data.
REQ-007 ctl_data_out  out  32  control read data, combinational from ctl_addr.
REQ-008 cpu_stb, cpu_we  in  1 each  CPU video-memory write strobe and enable.
REQ-009 cpu_addr  in  15  CPU video word address {row[9:0], word[4:0]}, row 0 = CPU row 0.
REQ-010 cpu_data_in  in  32  CPU video write data.
REQ-011 vid_stb, vid_we  out  1 each  video controller write strobe and enable.
REQ-012 vid_addr  out  15  video word address, in the same CPU-view format as cpu_addr.
REQ-013 vid_data  out  32  video write data.
REQ-014 busy  out  1  fill in progress.
REQ-015 done  out  1  one-cycle pulse after the last fill write.

Function
REQ-016 Register fields:
- GEOM: [4:0]=x0, [12:8]=wm1 (width-1, in words), [25:16]=y0.
- HGT: [9:0]=hm1 (height-1, in rows).
- PAT: 32-bit fill word.
- CMD write: bit0=start, bit1=invert-pattern-on-odd-rows.
- STAT read: bit0=busy. GEOM, HGT and PAT read back their stored values; unused bits read 0.
REQ-017 GEOM, HGT and PAT are writable at any time; the engine copies them into working registers on an accepted start.
REQ-018 FSM states are IDLE and FILL; a start while in FILL is ignored.
REQ-019 Start accepted at edge n: busy=1 from n+1, first fill write presented on vid_* from n+1.
REQ-020 Clipping:
- x_end = min(x0+wm1, 31), evaluated in 6-bit arithmetic.
- y_end = min(y0+hm1, 767), evaluated in 11-bit arithmetic.
- No column wrap into the next row; no row wrap past 767.
REQ-021 A start with y0>767 writes nothing, pulses done at n+1, and leaves busy at 0.
REQ-022 Fill order is row-major: x from x0 to x_end, then y+1 with x restarting at x0.
REQ-023 Fill data is PAT; if invert is set, rows with (y-y0) odd use ~PAT.
REQ-024 Arbitration: CPU has priority.
- In a cycle where cpu_stb&cpu_we=1, vid_* carries the CPU write and the fill pointer holds.
- The fill resumes on the next free cycle.
- No fill write is lost or duplicated.
REQ-025 With cpu_stb&cpu_we=1, the next edge registers vid_stb=1, vid_we=1, vid_addr=cpu_addr, vid_data=cpu_data_in; CPU path latency is 1 clk in both IDLE and FILL.
REQ-026 vid_stb=0 in any cycle with neither a CPU write nor a fill write.
REQ-027 All vid_* outputs, busy and done are registered.
REQ-028 After the final fill write is presented (x=x_end, y=y_end):
- the FSM returns to IDLE;
- busy=0 and done=1 in the following cycle, for exactly one cycle.
REQ-029 Total fill writes = (x_end-x0+1)*(y_end-y0+1), exactly once each.

Reset
REQ-030 On rst, the following are 0 and the FSM is IDLE: vid_stb, vid_we, vid_addr, vid_data, busy, done, all registers.
REQ-031 rst during FILL aborts the fill: no further fill writes and no done pulse.
REQ-032 rst has priority over a simultaneous start or CPU write.

Structure
REQ-033 Package vid_pkg holds:
- VID_WORDS_PER_ROW=32, VID_ROWS=768;
- register offsets REG_GEOM..REG_CMD;
- FSM state enum.
REQ-034 The address/data generator (x/y counters, clipping, row parity) is sub-module vid_fill_agen; arbitration, registers and FSM stay in vid_fill.
REQ-035 Target size is 120-400 RTL lines.

Verification
REQ-036 Basic fill: x0=2, wm1=3, y0=10, hm1=1, PAT=0xA5A5A5A5 -> exactly 8 writes in consecutive cycles to 0x142..0x145, 0x162..0x165, all data 0xA5A5A5A5; then done pulse, busy=0.
REQ-037 Clipping: x0=30, wm1=5, y0=766, hm1=4 -> writes only to 0x5FDE, 0x5FDF, 0x5FFE, 0x5FFF; then done.
REQ-038 Checkerboard: invert=1, PAT=0xFFFF0000, x0=0, wm1=0, y0=0, hm1=2 -> data 0xFFFF0000, 0x0000FFFF, 0xFFFF0000.
REQ-039 Arbitration: CPU write addr=0x0001, data=0x12345678 issued during the 2nd cycle of fill x0=0, wm1=3, y0=0, hm1=0 -> vid sequence 0x0000, CPU 0x0001/0x12345678, 0x0001/PAT, 0x0002, 0x0003; 5 writes in total.
REQ-040 Reset and start protection:
- rst asserted during a 32x768 fill -> vid_stb=0 from the next edge and no done pulse.
- A start issued while busy -> no restart and the write count is unchanged.
REQ-041 Out-of-range start: y0=800 -> zero writes, done pulses at n+1, busy stays 0.
